// File: rtl/debounce_scheduler_pkg.sv
// Shared types and defaults for the debounce scheduler: arbiter states,
// default timing constants and the channel-index width helper.
package debounce_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEF_TICKDIV  = 4;
  localparam int DEF_WAITTIME = 3;

  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scheduler_channel.sv
// One input channel: two-flop synchronizer, tick-paced stability counter,
// debounced level and one-cycle edge pulses registered alongside it.
module debounce_channel
  import debounce_scheduler_pkg::*;
#(
  parameter int WAITTIME = DEF_WAITTIME,
  parameter int COUNTERW = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  input  logic tick,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  logic                sync0, sync1;
  logic [COUNTERW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      cnt          <= '0;
      conditioned  <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      sync0        <= noisy;
      sync1        <= sync0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      // Any agreement with the current level restarts the stability window.
      if (conditioned == sync1) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == COUNTERW'(WAITTIME)) begin
          conditioned  <= sync1;
          cnt          <= '0;
          positiveedge <= sync1;
          negativeedge <= ~sync1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// NCHAN debounced inputs sharing one prescaler; confirmed edges become
// per-channel pending events served round-robin over a valid/ready port.
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int NCHAN    = 4,
  parameter int CHANW    = chan_w(NCHAN),
  parameter int TICKDIV  = DEF_TICKDIV,
  parameter int TICKW    = 3,
  parameter int WAITTIME = DEF_WAITTIME,
  parameter int COUNTERW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCHAN-1:0] noisysignal,
  output logic [NCHAN-1:0] conditioned,
  output logic [NCHAN-1:0] positiveedge,
  output logic [NCHAN-1:0] negativeedge,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [CHANW-1:0] event_channel,
  output logic             event_rising,
  output logic [NCHAN-1:0] overrun,
  input  logic             overrun_clear
);

  logic [TICKW-1:0] presc;
  logic             tick;

  assign tick = (presc == TICKW'(TICKDIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_ch
    debounce_channel #(
      .WAITTIME (WAITTIME),
      .COUNTERW (COUNTERW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .noisy        (noisysignal[g]),
      .tick         (tick),
      .conditioned  (conditioned[g]),
      .positiveedge (positiveedge[g]),
      .negativeedge (negativeedge[g])
    );
  end

  arb_state_t       state;
  logic [CHANW-1:0] rr_ptr;
  logic [NCHAN-1:0] pending, pend_rise, pend_clr, edge_any;
  logic             grant_found;
  logic [CHANW-1:0] grant_idx;

  assign edge_any = positiveedge | negativeedge;

  // Descending scan so the channel closest to rr_ptr is the one left standing.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NCHAN]) begin
        grant_found = 1'b1;
        grant_idx   = CHANW'((int'(rr_ptr) + k) % NCHAN);
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NCHAN; i++)
      pend_clr[i] = (state == IDLE) && grant_found && (grant_idx == CHANW'(i));
  end

  // A new edge beats a same-cycle grant clear and is not counted as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      pend_rise <= '0;
      overrun   <= '0;
    end else begin
      pending   <= (pending & ~pend_clr) | edge_any;
      pend_rise <= (pend_rise & ~edge_any) | (positiveedge & edge_any);
      overrun   <= (overrun_clear ? '0 : overrun) | (edge_any & pending & ~pend_clr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      event_valid   <= 1'b0;
      event_channel <= '0;
      event_rising  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            event_channel <= grant_idx;
            event_rising  <= pend_rise[grant_idx];
            event_valid   <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            rr_ptr      <= (event_channel == CHANW'(NCHAN - 1)) ? '0 : event_channel + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler: latency/pulse checks inline, event
// port checked against a queue of expected {channel, rising} entries.
module tb_debounce_scheduler;

  localparam int NCHAN = 4;
  localparam int CHANW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCHAN-1:0] noisysignal;
  logic [NCHAN-1:0] conditioned, positiveedge, negativeedge, overrun;
  logic             event_valid, event_ready, event_rising, overrun_clear;
  logic [CHANW-1:0] event_channel;

  int tests = 0;
  int fails = 0;
  int pcnt [NCHAN];
  int ncnt [NCHAN];
  logic [CHANW:0] sbq [$];

  always #5 clk = ~clk;

  debounce_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .noisysignal   (noisysignal),
    .conditioned   (conditioned),
    .positiveedge  (positiveedge),
    .negativeedge  (negativeedge),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_channel (event_channel),
    .event_rising  (event_rising),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_level(input int ch, input logic lvl, output int lat);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (conditioned[ch] !== lvl && n < 60);
    lat = n - 1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (event_valid !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check("offer_timeout", 32'(event_valid), 32'd1);
  endtask

  // Edge pulse counters and event scoreboard, sampled mid-cycle.
  initial begin
    for (int c = 0; c < NCHAN; c++) begin
      pcnt[c] = 0;
      ncnt[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (positiveedge[c] === 1'b1) pcnt[c]++;
      if (negativeedge[c] === 1'b1) ncnt[c]++;
    end
    if (reset === 1'b0 && event_valid === 1'b1 && event_ready === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_event", {event_channel, event_rising}, 32'hFFFF);
      else                 check("event", {event_channel, event_rising}, sbq.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p, n, w;
    reset = 1'b1; noisysignal = '0; event_ready = 1'b0; overrun_clear = 1'b0;
    step(3);
    check("rst_cond",  conditioned, 0);
    check("rst_edges", {positiveedge, negativeedge}, 0);
    check("rst_valid", event_valid, 0);
    check("rst_ovr",   overrun, 0);
    reset = 1'b0;
    step(2);

    // Clean rise then fall on ch0, consumer always ready.
    event_ready = 1'b1;
    p = pcnt[0];
    sbq.push_back({2'd0, 1'b1});
    noisysignal[0] = 1'b1;
    wait_level(0, 1'b1, lat);
    check("rise_lat_in_14_17", 32'(lat >= 14 && lat <= 17), 1);
    check("pos_pulse_hi", positiveedge[0], 1);
    step(1);
    check("pos_pulse_lo", positiveedge[0], 0);
    step(25);
    check("pos_count", pcnt[0] - p, 1);
    check("sb_clean_rise", sbq.size(), 0);
    n = ncnt[0];
    sbq.push_back({2'd0, 1'b0});
    noisysignal[0] = 1'b0;
    wait_level(0, 1'b0, lat);
    check("fall_lat_in_14_17", 32'(lat >= 14 && lat <= 17), 1);
    check("neg_pulse_hi", negativeedge[0], 1);
    step(1);
    check("neg_pulse_lo", negativeedge[0], 0);
    step(25);
    check("neg_count", ncnt[0] - n, 1);
    check("sb_clean_fall", sbq.size(), 0);

    // Glitches on ch1: short pulse, then 3-clk bounce, then settle high.
    p = pcnt[1]; n = ncnt[1];
    noisysignal[1] = 1'b1; step(5);
    noisysignal[1] = 1'b0; step(25);
    for (int i = 0; i < 10; i++) begin
      noisysignal[1] = ~noisysignal[1];
      step(3);
    end
    check("glitch_edges", (pcnt[1] - p) + (ncnt[1] - n), 0);
    check("glitch_cond", conditioned[1], 0);
    sbq.push_back({2'd1, 1'b1});
    noisysignal[1] = 1'b1;
    wait_level(1, 1'b1, lat);
    check("settle_cond", conditioned[1], 1);
    step(25);
    check("settle_one_rise", pcnt[1] - p, 1);
    check("sb_glitch", sbq.size(), 0);

    // Round-robin: ch0 held in OFFER while ch2, ch3 queue up.
    event_ready = 1'b0;
    sbq.push_back({2'd0, 1'b1});
    noisysignal[0] = 1'b1;
    wait_valid();
    check("rr_first_chan", event_channel, 0);
    sbq.push_back({2'd2, 1'b1}); noisysignal[2] = 1'b1; step(25);
    sbq.push_back({2'd3, 1'b1}); noisysignal[3] = 1'b1; step(25);
    event_ready = 1'b1; step(10); event_ready = 1'b0;
    check("sb_rr_023", sbq.size(), 0);
    sbq.push_back({2'd0, 1'b0}); sbq.push_back({2'd1, 1'b0});
    noisysignal[0] = 1'b0; noisysignal[1] = 1'b0;
    step(25);
    event_ready = 1'b1; step(10); event_ready = 1'b0;
    check("sb_rr_01", sbq.size(), 0);

    // Overrun and backpressure: ch3 offered and stalled, ch2 pends and overruns.
    sbq.push_back({2'd3, 1'b0});
    noisysignal[3] = 1'b0;
    wait_valid();
    noisysignal[2] = 1'b0; step(25);
    check("ovr_none", overrun, 0);
    noisysignal[2] = 1'b1; step(25);
    noisysignal[2] = 1'b0; step(25);
    check("ovr_set", overrun, 4'b0100);
    sbq.push_back({2'd2, 1'b0});
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {event_valid, event_channel, event_rising}, {1'b1, 2'd3, 1'b0});
      step(1);
    end
    overrun_clear = 1'b1; step(1); overrun_clear = 1'b0;
    check("ovr_clr", overrun, 0);
    event_ready = 1'b1; step(1); event_ready = 1'b0;
    check("bp_drop", event_valid, 0);
    step(1);
    check("regrant", {event_valid, event_channel, event_rising}, {1'b1, 2'd2, 1'b0});
    noisysignal[2] = 1'b1; step(25);
    check("ovr_pend_only", overrun, 0);
    noisysignal[2] = 1'b0;
    w = 0;
    while (negativeedge[2] !== 1'b1 && w < 60) begin
      step(1);
      w++;
    end
    overrun_clear = 1'b1; step(1); overrun_clear = 1'b0;
    check("ovr_set_beats_clr", overrun, 4'b0100);
    sbq.push_back({2'd2, 1'b0});
    event_ready = 1'b1; step(10); event_ready = 1'b0;
    check("sb_ovr", sbq.size(), 0);

    // Async reset mid-OFFER (ch3) and mid-count (ch1); nothing may survive.
    noisysignal[2] = 1'b1; noisysignal[3] = 1'b1;
    wait_valid();
    step(20);
    check("pre_rst_cond", conditioned, 4'b1100);
    noisysignal[1] = 1'b1; step(6);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", event_valid, 0);
    check("async_rst_cond",  conditioned, 0);
    check("async_rst_evt",   {event_channel, event_rising}, 0);
    check("async_rst_ovr",   overrun, 0);
    noisysignal = '0;
    step(2);
    reset = 1'b0;
    event_ready = 1'b1;
    step(40);
    check("post_rst_valid", event_valid, 0);
    check("post_rst_cond",  conditioned, 0);
    check("post_rst_edges", {positiveedge, negativeedge}, 0);
    check("sb_end", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
